// File: rtl/accel_filter.sv
// Accelerometer Y-axis conditioning: resynchronise, stability-qualify, moving-average,
// deadband, then publish a signed tilt value with a one-cycle valid pulse.
module accel_filter #(
    parameter int STABLE_CYCLES  = 4,
    parameter int REFRESH_CYCLES = 400000,
    parameter int LOG2_DEPTH     = 3,
    parameter int DEADBAND       = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] raw_data,
    output logic [15:0] accel_out,
    output logic        accel_valid,
    output logic [1:0]  tilt,
    output logic        window_full
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SW    = 16 + LOG2_DEPTH;
    localparam int STW   = $clog2(STABLE_CYCLES + 1);
    localparam int RFW   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int FW    = LOG2_DEPTH + 1;

    localparam logic signed [SW-1:0] DB_POS = SW'(DEADBAND);
    localparam logic signed [SW-1:0] DB_NEG = -DB_POS;

    localparam logic [1:0] TILT_CENTRE = 2'b00;
    localparam logic [1:0] TILT_RIGHT  = 2'b01;
    localparam logic [1:0] TILT_LEFT   = 2'b10;

    logic [15:0]           r_s1, r_s2, r_hold;
    logic [STW-1:0]        r_stab;
    logic [RFW-1:0]        r_ref;
    logic signed [15:0]    r_buf [DEPTH];
    logic [LOG2_DEPTH-1:0] r_wr;
    logic [FW-1:0]         r_fill;
    logic signed [SW-1:0]  r_sum;
    logic                  r_full;
    logic                  r_acc_d;

    logic                  w_same, w_first, w_refresh, w_acc;
    logic signed [SW-1:0]  w_old, w_new, w_avg;

    assign w_same    = (r_s2 == r_hold);
    assign w_first   = w_same && (r_stab == STW'(STABLE_CYCLES - 1));
    // A change on s2 clears w_same, so a coincident refresh is cancelled.
    assign w_refresh = w_same && (r_stab == STW'(STABLE_CYCLES))
                              && (r_ref == RFW'(REFRESH_CYCLES - 1));
    assign w_acc     = w_first || w_refresh;

    assign w_old = $signed({{LOG2_DEPTH{r_buf[r_wr][15]}}, r_buf[r_wr]});
    assign w_new = $signed({{LOG2_DEPTH{r_s2[15]}}, r_s2});
    assign w_avg = r_sum >>> LOG2_DEPTH;

    assign window_full = r_full;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_hold <= '0;
            r_stab <= '0;
            r_ref  <= '0;
        end else begin
            r_s1   <= raw_data;
            r_s2   <= r_s1;
            r_hold <= r_s2;
            if (!w_same) begin
                r_stab <= '0;
                r_ref  <= '0;
            end else if (r_stab != STW'(STABLE_CYCLES)) begin
                r_stab <= r_stab + STW'(1);
            end else if (w_refresh) begin
                r_ref <= '0;
            end else begin
                r_ref <= r_ref + RFW'(1);
            end
        end
    end

    // Running sum tracks the window contents; empty slots hold zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
            r_wr    <= '0;
            r_fill  <= '0;
            r_sum   <= '0;
            r_full  <= 1'b0;
            r_acc_d <= 1'b0;
        end else begin
            r_acc_d <= w_acc;
            if (w_acc) begin
                r_sum       <= r_sum - w_old + w_new;
                r_buf[r_wr] <= $signed(r_s2);
                r_wr        <= r_wr + LOG2_DEPTH'(1);
                if (r_fill != FW'(DEPTH)) r_fill <= r_fill + FW'(1);
                if (r_fill == FW'(DEPTH - 1)) r_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            accel_out   <= '0;
            accel_valid <= 1'b0;
            tilt        <= TILT_CENTRE;
        end else begin
            accel_valid <= r_acc_d;
            if (r_acc_d) begin
                if (w_avg >= DB_POS) begin
                    accel_out <= w_avg[15:0];
                    tilt      <= TILT_RIGHT;
                end else if (w_avg <= DB_NEG) begin
                    accel_out <= w_avg[15:0];
                    tilt      <= TILT_LEFT;
                end else begin
                    accel_out <= '0;
                    tilt      <= TILT_CENTRE;
                end
            end
        end
    end
endmodule

// File: tb/tb_accel_filter.sv
// Bench for accel_filter: table of hold-segments with hand-derived end states, a reset
// corner case, and random segments, all shadowed every cycle by a run-length reference model.
module tb_accel_filter;
    localparam int S     = 4;
    localparam int R     = 20;
    localparam int L     = 3;
    localparam int DEPTH = 8;
    localparam int DB    = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] raw_data;
    logic [15:0] accel_out;
    logic        accel_valid;
    logic [1:0]  tilt;
    logic        window_full;

    always #5 clock = ~clock;

    accel_filter #(.STABLE_CYCLES(S), .REFRESH_CYCLES(R), .LOG2_DEPTH(L), .DEADBAND(DB)) dut (
        .clock(clock), .reset(reset), .raw_data(raw_data), .accel_out(accel_out),
        .accel_valid(accel_valid), .tilt(tilt), .window_full(window_full)
    );

    typedef struct {
        logic [15:0] raw;
        int          cycles;
        logic [15:0] out;
        logic [1:0]  tilt;
        logic        full;
        int          pulses;
        int          first;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int pulses;

    // Reference model: a value is accepted when it has been seen S+1 times in a row
    // at the synchroniser output, then every R further cycles while unchanged.
    logic [15:0] m_s1, m_s2, m_last;
    int          m_run, m_cnt, m_avg;
    bit          m_pend;
    int          q[$];
    logic [15:0] e_out;
    logic [1:0]  e_tilt;
    logic        e_valid, e_full;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_last = '0; m_run = 1;
        m_cnt = 0; m_avg = 0; m_pend = 0; q.delete();
        e_out = '0; e_tilt = 2'b00; e_valid = 1'b0; e_full = 1'b0;
    endtask

    task automatic model_step();
        logic [15:0] v;
        int sum;
        e_valid = 1'b0;
        if (m_pend) begin
            e_valid = 1'b1;
            if (m_avg >= DB) begin
                e_out = 16'(m_avg); e_tilt = 2'b01;
            end else if (m_avg <= -DB) begin
                e_out = 16'(m_avg); e_tilt = 2'b10;
            end else begin
                e_out = '0; e_tilt = 2'b00;
            end
            m_pend = 0;
        end
        v = m_s2;
        if (v == m_last) m_run++;
        else begin
            m_run = 1; m_last = v;
        end
        if (m_run == S + 1 || (m_run > S + 1 && (m_run - S - 1) % R == 0)) begin
            q.push_back(int'($signed(v)));
            if (q.size() > DEPTH) void'(q.pop_front());
            sum = 0;
            foreach (q[i]) sum += q[i];
            m_avg = (sum >= 0) ? sum / DEPTH : -((-sum + DEPTH - 1) / DEPTH);
            m_cnt++;
            m_pend = 1;
        end
        e_full = (m_cnt >= DEPTH);
        m_s2 = m_s1;
        m_s1 = raw_data;
    endtask

    task automatic tick();
        @(posedge clock);
        if (!reset) model_step();
        @(negedge clock);
        if (accel_valid) pulses++;
        check("valid", {31'd0, accel_valid}, {31'd0, e_valid});
        check("out", {16'd0, accel_out}, {16'd0, e_out});
        check("tilt", {30'd0, tilt}, {30'd0, e_tilt});
        check("full", {31'd0, window_full}, {31'd0, e_full});
    endtask

    initial begin
        vec_t tbl[15];
        int   first_at;
        int   len;
        logic [15:0] v;

        tbl[0]  = '{16'h0000,  10, 16'h0000, 2'b00, 1'b0, 1,  5};
        tbl[1]  = '{16'h0400,   8, 16'h0080, 2'b01, 1'b0, 1,  8};
        tbl[2]  = '{16'h0400, 140, 16'h0400, 2'b01, 1'b1, 7, 20};
        tbl[3]  = '{16'hFC00,   8, 16'h0300, 2'b01, 1'b1, 1,  8};
        tbl[4]  = '{16'hFC00, 140, 16'hFC00, 2'b10, 1'b1, 7, 20};
        tbl[5]  = '{16'h0000,   8, 16'hFC80, 2'b10, 1'b1, 1,  8};
        tbl[6]  = '{16'h7FFF,   3, 16'hFC80, 2'b10, 1'b1, 0,  0};
        tbl[7]  = '{16'h0000,  10, 16'hFD00, 2'b10, 1'b1, 1,  8};
        tbl[8]  = '{16'h0020, 150, 16'h0000, 2'b00, 1'b1, 8,  8};
        tbl[9]  = '{16'h8000, 150, 16'h8000, 2'b10, 1'b1, 8,  8};
        tbl[10] = '{16'h7FFF, 150, 16'h7FFF, 2'b01, 1'b1, 8,  8};
        tbl[11] = '{16'h0040, 150, 16'h0040, 2'b01, 1'b1, 8,  8};
        tbl[12] = '{16'h003F, 150, 16'h0000, 2'b00, 1'b1, 8,  8};
        tbl[13] = '{16'hFFC0, 150, 16'hFFC0, 2'b10, 1'b1, 8,  8};
        tbl[14] = '{16'hFFC1, 150, 16'h0000, 2'b00, 1'b1, 8,  8};

        reset = 1'b1;
        raw_data = '0;
        pulses = 0;
        model_reset();
        repeat (3) tick();
        check("rst_out", {16'd0, accel_out}, 32'd0);
        check("rst_valid", {31'd0, accel_valid}, 32'd0);
        check("rst_tilt", {30'd0, tilt}, 32'd0);
        check("rst_full", {31'd0, window_full}, 32'd0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            raw_data = tbl[i].raw;
            pulses = 0;
            first_at = 0;
            for (int c = 1; c <= tbl[i].cycles; c++) begin
                tick();
                if (accel_valid && first_at == 0) first_at = c;
            end
            check($sformatf("vec%0d_out", i), {16'd0, accel_out}, {16'd0, tbl[i].out});
            check($sformatf("vec%0d_tilt", i), {30'd0, tilt}, {30'd0, tbl[i].tilt});
            check($sformatf("vec%0d_full", i), {31'd0, window_full}, {31'd0, tbl[i].full});
            check($sformatf("vec%0d_pulses", i), 32'(pulses), 32'(tbl[i].pulses));
            check($sformatf("vec%0d_first", i), 32'(first_at), 32'(tbl[i].first));
        end

        // Reset lands two cycles before the pulse a new value would produce.
        raw_data = 16'h1234;
        pulses = 0;
        repeat (5) tick();
        reset = 1'b1;
        model_reset();
        repeat (2) tick();
        check("midrst_out", {16'd0, accel_out}, 32'd0);
        check("midrst_tilt", {30'd0, tilt}, 32'd0);
        check("midrst_full", {31'd0, window_full}, 32'd0);
        check("midrst_pulses", 32'(pulses), 32'd0);
        reset = 1'b0;
        first_at = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (accel_valid && first_at == 0) first_at = c;
        end
        check("rel_first", 32'(first_at), 32'd8);
        check("rel_out", {16'd0, accel_out}, 32'h0246);
        check("rel_tilt", {30'd0, tilt}, 32'd1);
        check("rel_full", {31'd0, window_full}, 32'd0);

        v = 16'h0000;
        for (int s = 0; s < 90; s++) begin
            case ($urandom_range(0, 6))
                0: v = 16'($urandom);
                1: v = 16'h8000;
                2: v = 16'h7FFF;
                3: v = 16'($urandom_range(0, 1023)) - 16'd512;
                4: v = 16'h0200;
                5: v = 16'hFE00;
                default: ;
            endcase
            raw_data = v;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(25, 50))
                                              : int'($urandom_range(1, 8));
            repeat (len) tick();
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                model_reset();
                repeat (2) tick();
                reset = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
